// File: rtl/vend_sequencer.sv
// ============================================================================
// vend_sequencer: coin-credit vending controller (collect / dispense / change)
// Optional: define VEND_TIMEOUT_EN for a 255-cycle dispenser timeout.
// Rev 1.0
// ============================================================================
`default_nettype none

module vend_sequencer #(
  parameter int unsigned PRICE0     = 1,
  parameter int unsigned PRICE1     = 2,
  parameter int unsigned PRICE2     = 2,
  parameter int unsigned PRICE3     = 3,
  parameter int unsigned MAX_CREDIT = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin1,
  input  logic       coin2,
  input  logic       sel_valid,
  input  logic [1:0] sel,
  input  logic       cancel,
  output logic       disp_req,
  output logic [1:0] disp_sel,
  input  logic       disp_ack,
  output logic       ret_req,
  input  logic       ret_ack,
  output logic [3:0] credit,
  output logic       rej1,
  output logic       rej2,
  output logic       low_credit,
  output logic       fault
);

  localparam logic [4:0] C_MAX = 5'(MAX_CREDIT);

  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_CHANGE   = 2'd2
  } state_t;

  function automatic logic [3:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = 4'(PRICE0);
      2'd1:    price_of = 4'(PRICE1);
      2'd2:    price_of = 4'(PRICE2);
      default: price_of = 4'(PRICE3);
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic       disp_req_q, disp_req_d;
  logic [1:0] disp_sel_q, disp_sel_d;
  logic       ret_req_q, ret_req_d;
  logic       rej1_q, rej1_d;
  logic       rej2_q, rej2_d;
  logic       low_credit_q, low_credit_d;
  logic       fault_d;
  logic [4:0] acc;
  logic [3:0] remain;
`ifdef VEND_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       fault_q;
`endif

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    disp_req_d   = disp_req_q;
    disp_sel_d   = disp_sel_q;
    ret_req_d    = ret_req_q;
    rej1_d       = 1'b0;
    rej2_d       = 1'b0;
    low_credit_d = 1'b0;
    fault_d      = 1'b0;
    acc          = {1'b0, credit_q};
    remain       = credit_q - price_of(disp_sel_q);

    case (state_q)
      ST_COLLECT: begin
        // coin2 is judged first so coin1 sees the post-coin2 total
        if (coin2) begin
          if (acc + 5'd2 <= C_MAX) acc = acc + 5'd2;
          else                     rej2_d = 1'b1;
        end
        if (coin1) begin
          if (acc + 5'd1 <= C_MAX) acc = acc + 5'd1;
          else                     rej1_d = 1'b1;
        end
        credit_d = acc[3:0];
        if (cancel) begin
          if (credit_q != 4'd0) begin
            state_d   = ST_CHANGE;
            ret_req_d = 1'b1;
          end
        end else if (sel_valid) begin
          if (credit_q >= price_of(sel)) begin
            state_d    = ST_DISPENSE;
            disp_sel_d = sel;
            disp_req_d = 1'b1;
          end else begin
            low_credit_d = 1'b1;
          end
        end
      end

      ST_DISPENSE: begin
        rej1_d = coin1;
        rej2_d = coin2;
        if (disp_ack) begin
          credit_d   = remain;
          disp_req_d = 1'b0;
          ret_req_d  = (remain != 4'd0);
          state_d    = (remain != 4'd0) ? ST_CHANGE : ST_COLLECT;
        end
`ifdef VEND_TIMEOUT_EN
        else if (tmo_q == 8'd254) begin
          fault_d    = 1'b1;
          disp_req_d = 1'b0;
          ret_req_d  = (credit_q != 4'd0);
          state_d    = (credit_q != 4'd0) ? ST_CHANGE : ST_COLLECT;
        end
`endif
      end

      ST_CHANGE: begin
        rej1_d = coin1;
        rej2_d = coin2;
        if (ret_ack && ret_req_q) begin
          credit_d = credit_q - 4'd1;
          if (credit_q == 4'd1) begin
            ret_req_d = 1'b0;
            state_d   = ST_COLLECT;
          end
        end
      end

      default: begin
        state_d    = ST_COLLECT;
        disp_req_d = 1'b0;
        ret_req_d  = 1'b0;
      end
    endcase
  end

`ifdef VEND_TIMEOUT_EN
  // counts cycles spent waiting; restarts on every entry into DISPENSE
  always_comb begin
    tmo_d = 8'd0;
    if (state_q == ST_DISPENSE && state_d == ST_DISPENSE) tmo_d = tmo_q + 8'd1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      credit_q     <= 4'd0;
      disp_req_q   <= 1'b0;
      disp_sel_q   <= 2'd0;
      ret_req_q    <= 1'b0;
      rej1_q       <= 1'b0;
      rej2_q       <= 1'b0;
      low_credit_q <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      tmo_q        <= 8'd0;
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      disp_req_q   <= disp_req_d;
      disp_sel_q   <= disp_sel_d;
      ret_req_q    <= ret_req_d;
      rej1_q       <= rej1_d;
      rej2_q       <= rej2_d;
      low_credit_q <= low_credit_d;
`ifdef VEND_TIMEOUT_EN
      tmo_q        <= tmo_d;
      fault_q      <= fault_d;
`endif
    end
  end

  assign credit     = credit_q;
  assign disp_req   = disp_req_q;
  assign disp_sel   = disp_sel_q;
  assign ret_req    = ret_req_q;
  assign rej1       = rej1_q;
  assign rej2       = rej2_q;
  assign low_credit = low_credit_q;
`ifdef VEND_TIMEOUT_EN
  assign fault      = fault_q;
`else
  assign fault      = 1'b0;
  wire unused_fault_d = fault_d;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vend_sequencer.sv
// Scoreboarded random + directed bench for vend_sequencer against a behavioural model.
`default_nettype none
`timescale 1ns/1ps

module tb_vend_sequencer;

  localparam int MAXC = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin1, coin2, sel_valid, cancel, disp_ack, ret_ack;
  logic [1:0] sel;
  logic       disp_req, ret_req, rej1, rej2, low_credit, fault;
  logic [1:0] disp_sel;
  logic [3:0] credit;

  always #5 clk = ~clk;

  vend_sequencer #(
    .PRICE0(1), .PRICE1(2), .PRICE2(2), .PRICE3(3), .MAX_CREDIT(MAXC)
  ) dut (
    .clk(clk), .rst(rst), .coin1(coin1), .coin2(coin2),
    .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
    .disp_req(disp_req), .disp_sel(disp_sel), .disp_ack(disp_ack),
    .ret_req(ret_req), .ret_ack(ret_ack), .credit(credit),
    .rej1(rej1), .rej2(rej2), .low_credit(low_credit), .fault(fault)
  );

  typedef struct packed {
    logic [3:0] credit;
    logic       disp_req;
    logic [1:0] disp_sel;
    logic       ret_req;
    logic       rej1;
    logic       rej2;
    logic       low_credit;
    logic       fault;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t exp;
  } item_t;

  item_t sb_q[$];
  int    cyc = 0;
  int    n_pass = 0;
  int    n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: a purchase "mode" plus a credit integer.
  localparam int M_IDLE = 0, M_VEND = 1, M_REFUND = 2;
  int m_mode, m_credit, m_sel, m_wait;

  function automatic int price(input int i);
    int p[4] = '{1, 2, 2, 3};
    return p[i];
  endfunction

  function automatic snap_t actual();
    snap_t a;
    a = {credit, disp_req, disp_sel, ret_req, rej1, rej2, low_credit, fault};
    return a;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_credit = 0; m_sel = 0; m_wait = 0;
  endtask

  task automatic model_apply(input bit c1, input bit c2, input bit sv, input int s,
                             input bit cn, input bit da, input bit ra, output snap_t e);
    bit r1, r2, lo, ft;
    int total;
    r1 = 0; r2 = 0; lo = 0; ft = 0;
    if (m_mode == M_IDLE) begin
      total = m_credit;
      if (c2) begin if (total + 2 > MAXC) r2 = 1; else total += 2; end
      if (c1) begin if (total + 1 > MAXC) r1 = 1; else total += 1; end
      if (cn) begin
        if (m_credit > 0) m_mode = M_REFUND;
      end else if (sv) begin
        if (m_credit >= price(s)) begin m_mode = M_VEND; m_sel = s; m_wait = 0; end
        else lo = 1;
      end
      m_credit = total;
    end else if (m_mode == M_VEND) begin
      r1 = c1; r2 = c2;
      if (da) begin
        m_credit -= price(m_sel);
        m_mode = (m_credit > 0) ? M_REFUND : M_IDLE;
      end else begin
        m_wait++;
`ifdef VEND_TIMEOUT_EN
        if (m_wait == 255) begin
          ft = 1;
          m_mode = (m_credit > 0) ? M_REFUND : M_IDLE;
        end
`endif
      end
    end else begin
      r1 = c1; r2 = c2;
      if (ra) begin
        m_credit--;
        if (m_credit == 0) m_mode = M_IDLE;
      end
    end
    e.credit     = 4'(m_credit);
    e.disp_req   = (m_mode == M_VEND);
    e.disp_sel   = 2'(m_sel);
    e.ret_req    = (m_mode == M_REFUND) && (m_credit > 0);
    e.rej1       = r1;
    e.rej2       = r2;
    e.low_credit = lo;
    e.fault      = ft;
  endtask

  // Drive one cycle of stimulus; the model's prediction goes to the scoreboard.
  task automatic step(input bit c1, input bit c2, input bit sv, input int s,
                      input bit cn, input bit da, input bit ra);
    item_t it;
    coin1 = c1; coin2 = c2; sel_valid = sv; sel = 2'(s);
    cancel = cn; disp_ack = da; ret_ack = ra;
    model_apply(c1, c2, sv, s, cn, da, ra, it.exp);
    it.cyc = cyc + 1;
    sb_q.push_back(it);
    @(posedge clk);
    @(negedge clk);
    #1;
    {coin1, coin2, sel_valid, cancel, disp_ack, ret_ack} = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string name);
    n_total++;
    if (actual() === '0) n_pass++;
    else $display("FAIL %s actual=%b required=%b", name, actual(), 12'b0);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic pulse_reset(input string name);
    rst = 1'b1;
    #1;
    check_zero(name);
    @(posedge clk);
    @(negedge clk);
    #1;
    check_zero({name, "_held"});
    rst = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    item_t it;
    if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      it = sb_q.pop_front();
      n_total++;
      if (it.cyc == cyc && actual() === it.exp) n_pass++;
      else $display("FAIL outputs cyc=%0d actual=%b required=%b (credit,dreq,dsel,rreq,rej1,rej2,low,fault)",
                    it.cyc, actual(), it.exp);
    end
  end

  initial begin
    rst = 1'b1;
    {coin1, coin2, sel_valid, cancel, disp_ack, ret_ack} = '0;
    sel = 2'd0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b0;

    // exact price, no change
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // change after dispense
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // overflow with simultaneous coins, then refund everything
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 2, 1, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    step(0, 0, 0, 0, 1, 0, 0);

    // low credit then cancel
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // busy rejection, then reset mid-change with credit 3
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    idle(1);
    pulse_reset("reset_mid_change");

`ifdef VEND_TIMEOUT_EN
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    idle(258);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(2);
`endif

    for (int i = 0; i < 3000; i++) begin
      bit c1, c2, sv, cn, da, ra;
      int s;
      cn = ($urandom_range(0, 11) == 0);
      c1 = !cn && ($urandom_range(0, 3) == 0);
      c2 = !cn && ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 4) == 0);
      s  = int'($urandom_range(0, 3));
      da = ($urandom_range(0, 4) == 0);
      ra = ($urandom_range(0, 2) == 0);
      step(c1, c2, sv, s, cn, da, ra);
    end

    pulse_reset("reset_end");

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_total++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameter PRICE0, 1: price of product 0, in 1-euro units.
REQ-002 Parameter PRICE1, 2: price of product 1.
REQ-003 Parameter PRICE2, 2: price of product 2.
REQ-004 Parameter PRICE3, 3: price of product 3.
REQ-005 Parameter MAX_CREDIT, 9: credit ceiling; legal range 3..15.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 coin1  in  1  one-cycle pulse: 1-euro coin inserted.
REQ-009 coin2  in  1  one-cycle pulse: 2-euro coin inserted.
REQ-010 sel_valid  in  1  one-cycle pulse: product selection.
REQ-011 sel  in  2  product index; sampled only with sel_valid.
REQ-012 cancel  in  1  one-cycle pulse: abort purchase and refund credit.
REQ-013 disp_req  out  1  dispenser request; held until acknowledged.
REQ-014 disp_sel  out  2  product index; stable while disp_req is high.
REQ-015 disp_ack  in  1  dispenser done; one-cycle pulse.
REQ-016 ret_req  out  1  request hopper to return one 1-euro coin.
REQ-017 ret_ack  in  1  one coin returned; one-cycle pulse.
REQ-018 credit  out  4  current registered credit.
REQ-019 rej1  out  1  one-cycle pulse: 1-euro coin rejected; pass back to chute.
REQ-020 rej2  out  1  one-cycle pulse: 2-euro coin rejected.
REQ-021 low_credit  out  1  one-cycle pulse: selection refused, credit below price.
REQ-022 fault  out  1  one-cycle pulse: dispenser timeout (see REQ-037).

Function
REQ-023 FSM states: COLLECT, DISPENSE, CHANGE. All outputs are registered.
REQ-024 COLLECT, coin accepted: credit increases by the coin value on the next edge.
REQ-025 COLLECT, coin rejected: if credit plus coin value exceeds MAX_CREDIT, a rej1/rej2 pulse is issued one cycle later and credit is unchanged.
REQ-026 COLLECT, coin1 and coin2 in the same cycle: coin2 is evaluated first; coin1 is then evaluated against the updated sum; each coin is accepted or rejected independently.
REQ-027 COLLECT, sel_valid: compared against the registered credit before any same-cycle coins.
- credit >= PRICE[sel]: latch sel into disp_sel, go to DISPENSE, assert disp_req next cycle.
- Otherwise: pulse low_credit, stay in COLLECT.
- Same-cycle coins are still credited in either case.
REQ-028 COLLECT, cancel: if credit > 0, go to CHANGE; if credit = 0, no effect.
REQ-029 COLLECT, cancel and sel_valid in the same cycle: cancel wins; the selection is ignored.
REQ-030 DISPENSE: disp_req stays high until disp_ack.
- On disp_ack: credit -= PRICE[disp_sel] and disp_req drops next cycle.
- Next state: CHANGE if the remainder is > 0, else COLLECT.
REQ-031 DISPENSE and CHANGE: every coin pulse is rejected (rej1/rej2). sel_valid and cancel are ignored.
REQ-032 CHANGE: ret_req is high while credit > 0.
- Each ret_ack while ret_req is high decrements credit by 1.
- When credit reaches 0, ret_req drops in the same cycle and the FSM returns to COLLECT.
REQ-033 disp_ack outside DISPENSE and ret_ack outside CHANGE are ignored.
REQ-034 Credit never exceeds MAX_CREDIT and never underflows.

Reset
REQ-035 While rst is asserted:
- state = COLLECT, credit = 0, disp_sel = 0.
- disp_req, ret_req, rej1, rej2, low_credit and fault are all 0.
REQ-036 Reset mid-DISPENSE or mid-CHANGE: requests drop immediately and held credit is discarded.

Configuration
REQ-037 With VEND_TIMEOUT_EN defined:
- An 8-bit counter runs in DISPENSE.
- If 255 cycles pass without disp_ack: pulse fault, drop disp_req, keep the full credit (no price deducted), go to CHANGE.
REQ-038 Without VEND_TIMEOUT_EN: DISPENSE waits indefinitely, fault is tied to 0, and no counter is instantiated.

Verification
REQ-039 Exact price: coin2, then sel=1 -> disp_req=1 with disp_sel=1; disp_ack -> credit 0, back to COLLECT, ret_req never asserted.
REQ-040 Change: coin2 twice (credit 4), then sel=3 -> after disp_ack, credit 1 and ret_req=1; one ret_ack -> credit 0, ret_req=0, COLLECT.
REQ-041 Overflow: credit 8, coin1 and coin2 in the same cycle -> coin2 rejected (rej2 pulse), coin1 accepted, credit 9.
REQ-042 Low credit and cancel: credit 1, sel=3 -> low_credit pulse, credit stays 1; cancel -> ret_req until one ret_ack, credit 0.
REQ-043 Busy rejection: coin1 during DISPENSE -> rej1 pulse, credit unchanged; rst asserted mid-CHANGE with credit 3 -> credit 0, ret_req=0 immediately.
REQ-044 VEND_TIMEOUT_EN: credit 2, sel=1, disp_ack withheld -> fault pulse at 255 cycles, then ret_req with credit 2 until two ret_acks.
